// File: rtl/pipe_front_regs.sv
// pipe_front_regs: PC, IF/ID and ID/EX pipeline registers with hazard control and event counters
//   clk, reset          : clock, asynchronous active-high reset
//   stall_f/stall_d     : hold fetch PC / hold IF/ID
//   flush_e             : insert bubble into ID/EX
//   pc_src_d/pc_branch_d: taken branch redirect from decode
//   instr_f             : fetched instruction for pc_f
//   decode fields in    : ctrl_d, rd1_d, rd2_d, sign_imm_d, rs_d, rt_d, rd_d
//   outputs             : pc_f, IF/ID contents, ID/EX contents, stall_cnt, flush_cnt
module pipe_front_regs #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CTRL_W   = 10,
   parameter int          CNT_W    = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall_f,
   input  logic              stall_d,
   input  logic              flush_e,
   input  logic              pc_src_d,
   input  logic [31:0]       pc_branch_d,
   input  logic [31:0]       instr_f,
   input  logic [CTRL_W-1:0] ctrl_d,
   input  logic [31:0]       rd1_d,
   input  logic [31:0]       rd2_d,
   input  logic [31:0]       sign_imm_d,
   input  logic [4:0]        rs_d,
   input  logic [4:0]        rt_d,
   input  logic [4:0]        rd_d,
   output logic [31:0]       pc_f,
   output logic [31:0]       instr_d,
   output logic [31:0]       pc_plus4_d,
   output logic              valid_d,
   output logic [CTRL_W-1:0] ctrl_e,
   output logic [31:0]       rd1_e,
   output logic [31:0]       rd2_e,
   output logic [31:0]       sign_imm_e,
   output logic [4:0]        rs_e,
   output logic [4:0]        rt_e,
   output logic [4:0]        rd_e,
   output logic              valid_e,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);
   logic [31:0]       pc_q, pc_d, instr_q, instr_d_n, pc4_q, pc4_d;
   logic              vd_q, vd_d, ve_q, ve_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d_n;
   logic [31:0]       rd1_q, rd1_d_n, rd2_q, rd2_d_n, imm_q, imm_d;
   logic [4:0]        rs_q, rs_d_n, rt_q, rt_d_n, rd_q, rd_d_n;
   logic [CNT_W-1:0]  scnt_q, scnt_d, fcnt_q, fcnt_d;
   logic [31:0]       pc_plus4;
   logic              flush_ev;

   assign pc_plus4 = pc_q + 32'd4;
   // a redirect only squashes IF/ID when decode is not held
   assign flush_ev = flush_e | (pc_src_d & ~stall_d);

   always_comb begin
      pc_d      = stall_f ? pc_q : pc_src_d ? pc_branch_d : pc_plus4;
      instr_d_n = stall_d ? instr_q : pc_src_d ? 32'd0 : instr_f;
      pc4_d     = stall_d ? pc4_q : pc_src_d ? 32'd0 : pc_plus4;
      vd_d      = stall_d ? vd_q : ~pc_src_d;
      ctrl_d_n  = (flush_e | ~vd_q) ? '0 : ctrl_d;
      rd1_d_n   = flush_e ? 32'd0 : rd1_d;
      rd2_d_n   = flush_e ? 32'd0 : rd2_d;
      imm_d     = flush_e ? 32'd0 : sign_imm_d;
      rs_d_n    = flush_e ? 5'd0 : rs_d;
      rt_d_n    = flush_e ? 5'd0 : rt_d;
      rd_d_n    = flush_e ? 5'd0 : rd_d;
      ve_d      = ~flush_e & vd_q;
      scnt_d    = (stall_d & ~&scnt_q) ? scnt_q + 1'b1 : scnt_q;
      fcnt_d    = (flush_ev & ~&fcnt_q) ? fcnt_q + 1'b1 : fcnt_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q    <= RESET_PC;
         instr_q <= '0;
         pc4_q   <= '0;
         vd_q    <= 1'b0;
         ctrl_q  <= '0;
         rd1_q   <= '0;
         rd2_q   <= '0;
         imm_q   <= '0;
         rs_q    <= '0;
         rt_q    <= '0;
         rd_q    <= '0;
         ve_q    <= 1'b0;
         scnt_q  <= '0;
         fcnt_q  <= '0;
      end else begin
         pc_q    <= pc_d;
         instr_q <= instr_d_n;
         pc4_q   <= pc4_d;
         vd_q    <= vd_d;
         ctrl_q  <= ctrl_d_n;
         rd1_q   <= rd1_d_n;
         rd2_q   <= rd2_d_n;
         imm_q   <= imm_d;
         rs_q    <= rs_d_n;
         rt_q    <= rt_d_n;
         rd_q    <= rd_d_n;
         ve_q    <= ve_d;
         scnt_q  <= scnt_d;
         fcnt_q  <= fcnt_d;
      end
   end

   assign pc_f       = pc_q;
   assign instr_d    = instr_q;
   assign pc_plus4_d = pc4_q;
   assign valid_d    = vd_q;
   assign ctrl_e     = ctrl_q;
   assign rd1_e      = rd1_q;
   assign rd2_e      = rd2_q;
   assign sign_imm_e = imm_q;
   assign rs_e       = rs_q;
   assign rt_e       = rt_q;
   assign rd_e       = rd_q;
   assign valid_e    = ve_q;
   assign stall_cnt  = scnt_q;
   assign flush_cnt  = fcnt_q;
endmodule

// File: tb/tb_pipe_front_regs.sv
// tb_pipe_front_regs: directed self-checking bench for pipe_front_regs
module tb_pipe_front_regs;
   logic        clk, reset, stall_f, stall_d, flush_e, pc_src_d;
   logic [31:0] pc_branch_d, instr_f, rd1_d, rd2_d, sign_imm_d;
   logic [9:0]  ctrl_d, ctrl_e;
   logic [4:0]  rs_d, rt_d, rd_d, rs_e, rt_e, rd_e;
   logic [31:0] pc_f, instr_d, pc_plus4_d, rd1_e, rd2_e, sign_imm_e;
   logic        valid_d, valid_e;
   logic [3:0]  stall_cnt, flush_cnt;
   int          checks = 0, failures = 0;

   pipe_front_regs #(.RESET_PC(32'h0), .CTRL_W(10), .CNT_W(4)) dut (
      .clk(clk), .reset(reset), .stall_f(stall_f), .stall_d(stall_d), .flush_e(flush_e),
      .pc_src_d(pc_src_d), .pc_branch_d(pc_branch_d), .instr_f(instr_f), .ctrl_d(ctrl_d),
      .rd1_d(rd1_d), .rd2_d(rd2_d), .sign_imm_d(sign_imm_d), .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d),
      .pc_f(pc_f), .instr_d(instr_d), .pc_plus4_d(pc_plus4_d), .valid_d(valid_d),
      .ctrl_e(ctrl_e), .rd1_e(rd1_e), .rd2_e(rd2_e), .sign_imm_e(sign_imm_e),
      .rs_e(rs_e), .rt_e(rt_e), .rd_e(rd_e), .valid_e(valid_e),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0; stall_f = 0; stall_d = 0; flush_e = 0; pc_src_d = 0;
      pc_branch_d = 0; instr_f = 0; ctrl_d = 10'h2AB; rd1_d = 32'hDEAD_0001;
      rd2_d = 32'hBEEF_0002; sign_imm_d = 32'hFFFF_FF80; rs_d = 5'd3; rt_d = 5'd7; rd_d = 5'd19;
      #1 reset = 1'b1;
      #1;
      chk("rst_pc", pc_f, 32'h0);
      chk("rst_valid_d", {31'd0, valid_d}, 32'd0);
      chk("rst_cnts", {24'd0, stall_cnt, flush_cnt}, 32'd0);
      @(negedge clk) reset = 1'b0;
      instr_f = 32'h1111_1111;
      step();
      chk("e1_pc", pc_f, 32'd4);
      chk("e1_instr_d", instr_d, 32'h1111_1111);
      chk("e1_pc4_d", pc_plus4_d, 32'd4);
      chk("e1_valid_d", {31'd0, valid_d}, 32'd1);
      instr_f = 32'h2222_2222;
      step();
      chk("e2_pc", pc_f, 32'd8);
      chk("e2_instr_d", instr_d, 32'h2222_2222);
      instr_f = 32'h3333_3333;
      step();
      chk("e3_pc", pc_f, 32'd12);
      chk("e3_instr_d", instr_d, 32'h3333_3333);
      chk("e3_valid_e", {31'd0, valid_e}, 32'd1);
      chk("e3_ctrl_e", {22'd0, ctrl_e}, 32'h2AB);
      chk("e3_rd1_e", rd1_e, 32'hDEAD_0001);
      chk("e3_imm_e", sign_imm_e, 32'hFFFF_FF80);
      chk("e3_regs_e", {17'd0, rs_e, rt_e, rd_e}, {17'd0, 5'd3, 5'd7, 5'd19});
      stall_f = 1; stall_d = 1; flush_e = 1; instr_f = 32'h4444_4444;
      for (int i = 1; i <= 2; i++) begin
         step();
         chk("hold_pc", pc_f, 32'd12);
         chk("hold_instr_d", instr_d, 32'h3333_3333);
         chk("bubble_valid_e", {31'd0, valid_e}, 32'd0);
         chk("bubble_ctrl_e", {22'd0, ctrl_e}, 32'd0);
         chk("bubble_rd2_e", rd2_e, 32'd0);
         chk("hold_stall_cnt", {28'd0, stall_cnt}, i);
         chk("hold_flush_cnt", {28'd0, flush_cnt}, i);
      end
      stall_f = 0; stall_d = 0; flush_e = 0; pc_src_d = 1; pc_branch_d = 32'h100;
      step();
      chk("br_pc", pc_f, 32'h100);
      chk("br_instr_d", instr_d, 32'd0);
      chk("br_valid_d", {31'd0, valid_d}, 32'd0);
      chk("br_flush_cnt", {28'd0, flush_cnt}, 32'd3);
      pc_src_d = 0; instr_f = 32'h5555_5555;
      step();
      chk("br2_valid_e", {31'd0, valid_e}, 32'd0);
      chk("br2_ctrl_e", {22'd0, ctrl_e}, 32'd0);
      chk("br2_pc", pc_f, 32'h104);
      chk("br2_instr_d", instr_d, 32'h5555_5555);
      pc_src_d = 1; pc_branch_d = 32'h900; stall_f = 1; stall_d = 1;
      step();
      chk("brst_pc", pc_f, 32'h104);
      chk("brst_instr_d", instr_d, 32'h5555_5555);
      chk("brst_valid_d", {31'd0, valid_d}, 32'd1);
      chk("brst_flush_cnt", {28'd0, flush_cnt}, 32'd3);
      chk("brst_stall_cnt", {28'd0, stall_cnt}, 32'd3);
      stall_f = 0; stall_d = 0; pc_branch_d = 32'hFFFF_FFFC;
      step();
      chk("wrap_pre_pc", pc_f, 32'hFFFF_FFFC);
      pc_src_d = 0; instr_f = 32'h6666_6666;
      step();
      chk("wrap_pc", pc_f, 32'd0);
      chk("wrap_pc4_d", pc_plus4_d, 32'd0);
      chk("wrap_instr_d", instr_d, 32'h6666_6666);
      stall_f = 1; instr_f = 32'h7777_7777;
      step();
      chk("sf_only_pc", pc_f, 32'd0);
      chk("sf_only_instr_d", instr_d, 32'h7777_7777);
      chk("sf_only_pc4_d", pc_plus4_d, 32'd4);
      chk("sf_only_stall_cnt", {28'd0, stall_cnt}, 32'd3);
      stall_f = 0; flush_e = 1; pc_src_d = 1; pc_branch_d = 32'h200;
      step();
      chk("pair_pc", pc_f, 32'h200);
      chk("pair_flush_cnt", {28'd0, flush_cnt}, 32'd5);
      flush_e = 0; pc_src_d = 0; stall_d = 1;
      for (int i = 0; i < 11; i++) step();
      chk("sat_pre", {28'd0, stall_cnt}, 32'd14);
      step();
      chk("sat_hit", {28'd0, stall_cnt}, 32'd15);
      for (int i = 0; i < 8; i++) step();
      chk("sat_hold", {28'd0, stall_cnt}, 32'd15);
      chk("sat_flush_cnt", {28'd0, flush_cnt}, 32'd5);
      stall_f = 1; flush_e = 1;
      step();
      #2 reset = 1'b1;
      #1;
      chk("arst_pc", pc_f, 32'h0);
      chk("arst_cnts", {24'd0, stall_cnt, flush_cnt}, 32'd0);
      chk("arst_instr_d", instr_d, 32'd0);
      chk("arst_valid_e", {31'd0, valid_e}, 32'd0);
      @(negedge clk) reset = 1'b0;
      stall_f = 0; stall_d = 0; flush_e = 0; instr_f = 32'h8888_8888;
      step();
      chk("post_pc", pc_f, 32'd4);
      chk("post_instr_d", instr_d, 32'h8888_8888);
      chk("post_valid_d", {31'd0, valid_d}, 32'd1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
